// File: rtl/beta_op_issue.sv
// Three-state issue engine for Beta OP/OPC instructions: reads operands from a
// 32x32 register file, drives an external ALU and writes the result back.
module beta_op_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [3:0]  alu_fn,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t      state_reg;
  logic [31:0] instr_reg;
  logic [31:0] wb_data_reg;
  logic [4:0]  wb_addr_reg;
  logic        wb_valid_reg;
  logic        illegal_reg;
  logic [31:0] rf_reg [0:31];

  logic [5:0]  opcode;
  logic [4:0]  rc, ra, rb;
  logic [15:0] lit;
  logic [31:0] ra_data, rb_data;
  logic        fn_ok, legal, rf_we;

  assign opcode = instr_reg[31:26];
  assign rc     = instr_reg[25:21];
  assign ra     = instr_reg[20:16];
  assign rb     = instr_reg[15:11];
  assign lit    = instr_reg[15:0];

  // R31 is hardwired to zero on every read port.
  assign ra_data  = (ra == 5'd31)       ? 32'd0 : rf_reg[ra];
  assign rb_data  = (rb == 5'd31)       ? 32'd0 : rf_reg[rb];
  assign dbg_data = (dbg_addr == 5'd31) ? 32'd0 : rf_reg[dbg_addr];

  always_comb begin
    fn_ok = 1'b0;
    case (opcode[3:0])
      4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h8,
      4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE: fn_ok = 1'b1;
      default:                            fn_ok = 1'b0;
    endcase
  end

  assign legal = opcode[5] & fn_ok;

  always_comb begin
    alu_fn = 4'd0;
    alu_a  = 32'd0;
    alu_b  = 32'd0;
    if (state_reg == EXEC) begin
      alu_fn = opcode[3:0];
      alu_a  = ra_data;
      alu_b  = opcode[4] ? {{16{lit[15]}}, lit} : rb_data;
    end
  end

  assign instr_ready = (state_reg == IDLE);
  assign wb_valid    = wb_valid_reg;
  assign wb_addr     = wb_addr_reg;
  assign wb_data     = wb_data_reg;
  assign illegal     = illegal_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      instr_reg    <= 32'd0;
      wb_data_reg  <= 32'd0;
      wb_addr_reg  <= 5'd0;
      wb_valid_reg <= 1'b0;
      illegal_reg  <= 1'b0;
    end else begin
      wb_valid_reg <= 1'b0;
      illegal_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (instr_valid) begin
            instr_reg <= instr;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          // Status flags are set here so they are high for exactly the WB cycle.
          wb_data_reg  <= alu_result;
          wb_addr_reg  <= rc;
          wb_valid_reg <= legal;
          illegal_reg  <= ~legal;
          state_reg    <= WB;
        end
        WB:      state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rf_we = (state_reg == WB) && wb_valid_reg && (wb_addr_reg != 5'd31);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_reg[i] <= 32'd0;
    end else if (rf_we) begin
      rf_reg[wb_addr_reg] <= wb_data_reg;
    end
  end

endmodule

// File: tb/tb_beta_op_issue.sv
// Directed bench for beta_op_issue: table of single instructions, a
// back-to-back throughput run and a reset-during-EXEC abort.
module tb_beta_op_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [3:0]  alu_fn;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  beta_op_issue dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_fn(alu_fn), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural Beta ALU
  always_comb begin
    case (alu_fn)
      4'h0: alu_result = alu_a + alu_b;
      4'h1: alu_result = alu_a - alu_b;
      4'h4: alu_result = {31'd0, alu_a == alu_b};
      4'h5: alu_result = {31'd0, $signed(alu_a) <  $signed(alu_b)};
      4'h6: alu_result = {31'd0, $signed(alu_a) <= $signed(alu_b)};
      4'h8: alu_result = alu_a & alu_b;
      4'h9: alu_result = alu_a | alu_b;
      4'hA: alu_result = alu_a ^ alu_b;
      4'hB: alu_result = ~(alu_a ^ alu_b);
      4'hC: alu_result = alu_a << alu_b[4:0];
      4'hD: alu_result = alu_a >> alu_b[4:0];
      4'hE: alu_result = $signed(alu_a) >>> alu_b[4:0];
      default: alu_result = 32'd0;
    endcase
  end

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic        wbv;
    logic        ill;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [4:0]  dbga;
    logic [31:0] dbgd;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    chk("ready_before", {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    instr       = v.ins;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("exec_ready", {31'd0, instr_ready}, 32'd0);
    chk("exec_fn", {28'd0, alu_fn}, {28'd0, v.fn});
    chk("exec_a", alu_a, v.a);
    chk("exec_b", alu_b, v.b);
    @(posedge clk); #1;
    chk("wb_ready", {31'd0, instr_ready}, 32'd0);
    chk("wb_valid", {31'd0, wb_valid}, {31'd0, v.wbv});
    chk("wb_illegal", {31'd0, illegal}, {31'd0, v.ill});
    if (v.wbv) begin
      chk("wb_addr", {27'd0, wb_addr}, {27'd0, v.addr});
      chk("wb_data", wb_data, v.data);
    end
    @(posedge clk); #1;
    chk("idle_ready", {31'd0, instr_ready}, 32'd1);
    chk("idle_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("idle_illegal", {31'd0, illegal}, 32'd0);
    dbg_addr = v.dbga;
    #1;
    chk("dbg_data", dbg_data, v.dbgd);
    $display("vec %0d instr=0x%08h fn=%0h a=0x%08h b=0x%08h dbg[%0d]=0x%08h",
             idx, v.ins, v.fn, v.a, v.b, v.dbga, dbg_data);
  endtask

  initial begin
    //            instr         fn    a             b             wbv   ill   addr   data          dbga   dbgd
    vecs[0] = '{32'hC03F0005, 4'h0, 32'd0,        32'd5,        1'b1, 1'b0, 5'd1,  32'd5,        5'd1,  32'd5};
    vecs[1] = '{32'hC441FFFF, 4'h1, 32'd5,        32'hFFFFFFFF, 1'b1, 1'b0, 5'd2,  32'd6,        5'd2,  32'd6};
    vecs[2] = '{32'h83E11000, 4'h0, 32'd5,        32'd6,        1'b1, 1'b0, 5'd31, 32'd11,       5'd31, 32'd0};
    vecs[3] = '{32'h88611000, 4'h2, 32'd5,        32'd6,        1'b0, 1'b1, 5'd3,  32'd0,        5'd3,  32'd0};
    vecs[4] = '{32'hE88200FF, 4'hA, 32'd6,        32'h000000FF, 1'b1, 1'b0, 5'd4,  32'h000000F9, 5'd4,  32'h000000F9};
    vecs[5] = '{32'h80421000, 4'h0, 32'd6,        32'd6,        1'b1, 1'b0, 5'd2,  32'd12,       5'd2,  32'd12};
    vecs[6] = '{32'hF0A10004, 4'hC, 32'd5,        32'd4,        1'b1, 1'b0, 5'd5,  32'h00000050, 5'd1,  32'd5};
    vecs[7] = '{32'h40200000, 4'h0, 32'd0,        32'd0,        1'b0, 1'b1, 5'd1,  32'd0,        5'd1,  32'd5};
    vecs[8] = '{32'h94C11000, 4'h5, 32'd5,        32'd12,       1'b1, 1'b0, 5'd6,  32'd1,        5'd6,  32'd1};

    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 32'd0;
    dbg_addr    = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_alu_fn", {28'd0, alu_fn}, 32'd0);
    chk("rst_dbg0", dbg_data, 32'd0);
    $display("reset done ready=%0b", instr_ready);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // R2 must be unaffected by the discarded R31 write and the illegal ops
    dbg_addr = 5'd2; #1;
    chk("r2_final", dbg_data, 32'd12);

    // Back-to-back: valid held high, ADDC R8,R31,1
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = 32'hC11F0001;
    for (int i = 0; i < 12; i++) begin
      chk("b2b_ready", {31'd0, instr_ready}, {31'd0, (i % 3) == 0});
      chk("b2b_wb_valid", {31'd0, wb_valid}, {31'd0, (i % 3) == 2});
      $display("b2b cycle %0d ready=%0b wb_valid=%0b", i, instr_ready, wb_valid);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    dbg_addr = 5'd8; #1;
    chk("b2b_r8", dbg_data, 32'd1);

    // Reset during EXEC of ADDC R3,R31,7
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = 32'hC07F0007;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("abort_exec_b", alu_b, 32'd7);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_wb_valid", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_ready", {31'd0, instr_ready}, 32'd1);
    @(posedge clk); #1;
    chk("abort_wb_valid2", {31'd0, wb_valid}, 32'd0);
    dbg_addr = 5'd3; #1;
    chk("abort_r3", dbg_data, 32'd0);
    dbg_addr = 5'd1; #1;
    chk("abort_r1_cleared", dbg_data, 32'd0);
    $display("reset abort ready=%0b r1=0x%08h", instr_ready, dbg_data);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/beta_op_issue.md
BETA_OP_ISSUE -- requirements
Module: beta_op_issue

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled on the clk rising edge.
REQ-004 instr_valid  input  1  an instruction word is offered.
REQ-005 instr_ready  output  1  the block accepts instr this cycle.
REQ-006 instr  input  32  Beta OP/OPC word: [31:26] opcode, [25:21] Rc, [20:16] Ra, [15:11] Rb, [15:0] literal.
REQ-007 alu_fn  output  4  function code to the ALU.
REQ-008 alu_a  output  32  ALU operand A.
REQ-009 alu_b  output  32  ALU operand B.
REQ-010 alu_result  input  32  combinational ALU result for the current alu_fn, alu_a and alu_b.
REQ-011 wb_valid  output  1  one-cycle pulse when a register write occurs or is suppressed.
REQ-012 wb_addr  output  5  destination register Rc.
REQ-013 wb_data  output  32  value written.
REQ-014 illegal  output  1  one-cycle pulse when the accepted opcode is unsupported.
REQ-015 dbg_addr  input  5  debug register-file read address.
REQ-016 dbg_data  output  32  combinational read of regfile[dbg_addr]; dbg_addr 31 SHALL return 0.

Function
REQ-017 SHALL hold a 32x32 register file; R31 SHALL read as 0 and writes to R31 SHALL be discarded.
REQ-018 FSM states SHALL be IDLE, EXEC and WB; only IDLE SHALL assert instr_ready.
REQ-019 IDLE: when instr_valid and instr_ready are both high, SHALL latch instr and go to EXEC; otherwise SHALL stay in IDLE.
REQ-020 EXEC: alu_fn SHALL equal opcode[3:0], and alu_a SHALL equal regfile[Ra].
REQ-021 EXEC: when opcode[5:4] is 2'b10 (OP), alu_b SHALL equal regfile[Rb]; when it is 2'b11 (OPC), alu_b SHALL equal the literal sign-extended to 32 bits.
REQ-022 EXEC SHALL capture alu_result into wb_data at the clock edge and SHALL then go to WB.
REQ-023 Outside EXEC, alu_fn, alu_a and alu_b SHALL be 0.
REQ-024 Legal opcodes SHALL be opcode[5] = 1 with opcode[3:0] in {0,1,4,5,6,8,9,A,B,C,D,E}; all other opcodes are illegal.
REQ-025 WB, legal opcode: wb_valid SHALL be 1, wb_addr SHALL equal Rc, regfile[Rc] SHALL be written at the clock edge (unless Rc = 31), and the FSM SHALL return to IDLE.
REQ-026 WB, illegal opcode: illegal SHALL be 1, wb_valid SHALL be 0, no register SHALL be written, and the FSM SHALL return to IDLE.
REQ-027 Latency: accept at edge N puts the block in EXEC in cycle N+1 and in WB in cycle N+2, and instr_ready SHALL be high again in cycle N+3; throughput is one instruction per 3 cycles.
REQ-028 A write in WB SHALL be visible to the next instruction's EXEC read (no hazard) and to dbg_data in the following cycle.
REQ-029 instr_valid asserted while the FSM is outside IDLE SHALL be ignored, with no side effects.
REQ-030 Rc = Ra = Rb SHALL read the old value and write the new value.

Reset
REQ-031 While reset = 1 at an edge: the FSM SHALL go to IDLE, all 32 registers SHALL clear to 0, and wb_valid, illegal, wb_addr and wb_data SHALL become 0.
REQ-032 Reset asserted in EXEC or WB SHALL abort the instruction, and no register write SHALL occur at that edge.
REQ-033 instr_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
(The bench drives alu_result from a behavioural ALU model.)
REQ-034 After reset, issue ADDC R1,R31,5 (0xC03F0005) -> in EXEC alu_fn = 0, alu_a = 0, alu_b = 5; wb_valid pulses two cycles after accept with wb_addr = 1 and wb_data = 5; dbg_data(1) = 5.
REQ-035 Issue SUBC R2,R1,-1 (0xC441FFFF) -> alu_b = 0xFFFFFFFF; R2 = 6.
REQ-036 Issue ADD R31,R1,R2 (0x83E11000) -> wb_valid pulses, but dbg_data(31) = 0 and R1/R2 are unchanged.
REQ-037 Issue opcode 0x22 (MUL) -> illegal pulses one cycle in WB, wb_valid = 0, and the register file is unchanged.
REQ-038 Hold instr_valid high continuously with back-to-back instructions -> exactly one accept every 3 cycles, and instr_ready is 0 in EXEC and WB.
REQ-039 Assert reset during EXEC of ADDC R3,R31,7 -> R3 stays 0, there is no wb_valid, and instr_ready is 1 in the first cycle after reset deasserts.
